// File: rtl/alu_pkg.sv
// Shared constants, opcodes and FSM state type for the ALU sequencing controller.
// Opcode values double as indices into the function-unit enable vector.
package alu_pkg;

  localparam int WIDTH = 4;
  localparam int NFUNC = 16;
  localparam int OPW   = 4;

  typedef logic [OPW-1:0] alu_op_t;

  localparam alu_op_t OP_ADD   = 4'd0;
  localparam alu_op_t OP_SUB   = 4'd1;
  localparam alu_op_t OP_AND   = 4'd2;
  localparam alu_op_t OP_OR    = 4'd3;
  localparam alu_op_t OP_XOR   = 4'd4;
  localparam alu_op_t OP_NOT   = 4'd5;
  localparam alu_op_t OP_SHL   = 4'd6;
  localparam alu_op_t OP_SHR   = 4'd7;
  localparam alu_op_t OP_INC   = 4'd8;
  localparam alu_op_t OP_DEC   = 4'd9;
  localparam alu_op_t OP_NAND  = 4'd10;
  localparam alu_op_t OP_NOR   = 4'd11;
  localparam alu_op_t OP_XNOR  = 4'd12;
  localparam alu_op_t OP_PASSA = 4'd13;
  localparam alu_op_t OP_PASSB = 4'd14;
  localparam alu_op_t OP_NEG   = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } alu_ctl_state_t;

endpackage

// File: rtl/onehot_dec.sv
// Binary-to-one-hot decoder with enable.
// All outputs are low whenever en is low.
module onehot_dec #(
  parameter int SELW = 4,
  parameter int NOUT = 16
) (
  input  logic            en,
  input  logic [SELW-1:0] sel,
  output logic [NOUT-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < NOUT; i++) begin
      if (en && (sel == SELW'(i))) y[i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_controller.sv
// Sequencer around the 16-unit ALU: accept request, enable one unit for a
// settle window, then capture result plus flags until the consumer takes it.
module alu_op_controller
  import alu_pkg::*;
#(
  parameter int WIDTH  = alu_pkg::WIDTH,
  parameter int NFUNC  = alu_pkg::NFUNC,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] fu_a,
  output logic [WIDTH-1:0] fu_b,
  output logic [NFUNC-1:0] fu_en,
  input  logic [WIDTH-1:0] fu_result,
  input  logic             fu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_op,
  output logic             out_zero,
  output logic             out_carry
);

  localparam logic [2:0] CNT_LOAD = 3'(SETTLE - 1);

  alu_ctl_state_t state_q, state_d;
  logic [2:0]     cnt_q;
  logic [3:0]     op_q;
  logic           accept;
  logic           capture;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == 3'd0) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      op_q    <= 4'd0;
      fu_a    <= '0;
      fu_b    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= CNT_LOAD;
        op_q  <= in_op;
        fu_a  <= in_a;
        fu_b  <= in_b;
      end else if (state_q == DRIVE && cnt_q != 3'd0) begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_op     <= 4'd0;
      out_zero   <= 1'b1;
      out_carry  <= 1'b0;
    end else if (capture) begin
      out_result <= fu_result;
      out_op     <= op_q;
      out_zero   <= (fu_result == '0);
      out_carry  <= fu_carry;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);

  // Enable derives only from registered state and opcode, so it cannot glitch
  // with the requester's inputs and drops asynchronously on reset.
  onehot_dec #(
    .SELW (4),
    .NOUT (NFUNC)
  ) u_dec (
    .en  (state_q == DRIVE),
    .sel (op_q),
    .y   (fu_en)
  );

endmodule

// File: tb/tb_alu_op_controller.sv
// Scoreboard bench for alu_op_controller with a behavioural ALU model
// driving the OR-combined function-unit bus.
module tb_alu_op_controller;
  import alu_pkg::*;

  localparam int S  = 1;
  localparam int S3 = 3;

  typedef struct {
    logic [3:0] op;
    logic [3:0] res;
    logic       z;
    logic       c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_op, in_a, in_b, fu_a, fu_b, fu_result;
  logic [15:0] fu_en;
  logic        fu_carry;
  logic [3:0]  out_result, out_op;
  logic        out_zero, out_carry;

  logic        in_valid3, in_ready3, out_valid3, out_ready3;
  logic [3:0]  in_op3, in_a3, in_b3, fu_a3, fu_b3, fu_result3;
  logic [15:0] fu_en3;
  logic        fu_carry3;
  logic [3:0]  out_result3, out_op3;
  logic        out_zero3, out_carry3;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_acc = 0;
  logic [3:0] cur_op = 4'd0;
  bit   rnd_mode = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_op_controller #(.WIDTH(4), .NFUNC(16), .SETTLE(S)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .fu_a(fu_a), .fu_b(fu_b), .fu_en(fu_en),
    .fu_result(fu_result), .fu_carry(fu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_op(out_op),
    .out_zero(out_zero), .out_carry(out_carry)
  );

  alu_op_controller #(.WIDTH(4), .NFUNC(16), .SETTLE(S3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .in_op(in_op3), .in_a(in_a3), .in_b(in_b3),
    .fu_a(fu_a3), .fu_b(fu_b3), .fu_en(fu_en3),
    .fu_result(fu_result3), .fu_carry(fu_carry3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_result(out_result3), .out_op(out_op3),
    .out_zero(out_zero3), .out_carry(out_carry3)
  );

  // Behavioural function unit: {carry, result} from plain integer arithmetic.
  function automatic logic [4:0] alu_ref(input int op, input logic [3:0] a, input logic [3:0] b);
    int x, y, r, c;
    x = int'(a);
    y = int'(b);
    r = 0;
    c = 0;
    case (op)
      0:  begin r = x + y; c = (r > 15) ? 1 : 0; end
      1:  begin r = x - y; c = (r < 0) ? 1 : 0; end
      2:  r = x & y;
      3:  r = x | y;
      4:  r = x ^ y;
      5:  r = ~x;
      6:  r = x * 2;
      7:  r = x / 2;
      8:  begin r = x + 1; c = (r > 15) ? 1 : 0; end
      9:  begin r = x - 1; c = (r < 0) ? 1 : 0; end
      10: r = ~(x & y);
      11: r = ~(x | y);
      12: r = ~(x ^ y);
      13: r = x;
      14: r = y;
      15: r = -x;
      default: r = 0;
    endcase
    return {1'(c), 4'(r & 15)};
  endfunction

  function automatic logic [4:0] bus_eval(input logic [15:0] en, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] acc;
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (en[i]) acc = acc | alu_ref(i, a, b);
    end
    return acc;
  endfunction

  always_comb {fu_carry, fu_result} = bus_eval(fu_en, fu_a, fu_b);
  always_comb {fu_carry3, fu_result3} = bus_eval(fu_en3, fu_a3, fu_b3);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int         n;
    exp_t       e;
    logic [4:0] rc;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(n), 32'd0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc = cyc;
    cur_op   = op;
    rc       = alu_ref(int'(op), a, b);
    e.op     = op;
    e.res    = rc[3:0];
    e.c      = rc[4];
    e.z      = (rc[3:0] == 4'd0);
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
  end

  int         run = 0;
  logic       ov_prev = 1'b0;
  logic       rdy_prev = 1'b1;
  logic [9:0] bundle_prev = '0;

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      run      = 0;
      ov_prev  = 1'b0;
      rdy_prev = 1'b1;
    end else begin
      chk("rdy_valid_excl", 32'(in_ready & out_valid), 32'd0);
      if (fu_en != 16'd0) begin
        chk("fu_en_onehot", 32'(fu_en), 32'(16'd1 << cur_op));
        run++;
      end else if (run > 0) begin
        chk("drive_len", 32'(run), 32'(S));
        run = 0;
      end
      if (out_valid && !ov_prev)
        chk("valid_latency", 32'(cyc - last_acc), 32'(S));
      if (out_valid && ov_prev && !rdy_prev)
        chk("hold_stable", 32'({out_op, out_result, out_zero, out_carry}), 32'(bundle_prev));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'(sb.size()));
        end else begin
          e = sb.pop_front();
          chk("out_op", 32'(out_op), 32'(e.op));
          chk("out_result", 32'(out_result), 32'(e.res));
          chk("out_zero", 32'(out_zero), 32'(e.z));
          chk("out_carry", 32'(out_carry), 32'(e.c));
        end
      end
      ov_prev     = out_valid;
      rdy_prev    = out_ready;
      bundle_prev = {out_op, out_result, out_zero, out_carry};
    end
  end

  initial begin
    int         hs, prev, n, hi;
    logic [3:0] r0;

    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    in_valid3 = 1'b0; in_op3 = '0; in_a3 = '0; in_b3 = '0; out_ready3 = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_fu_en", 32'(fu_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd1);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_op", 32'(out_op), 32'd0);
    chk("rst_out_carry", 32'(out_carry), 32'd0);
    chk("rst_fu_ab", 32'({fu_a, fu_b}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Incrementor 7 -> 8
    out_ready = 1'b1;
    issue(OP_INC, 4'h7, 4'(($urandom)));
    chk("inc7_fu_en", 32'(fu_en), 32'h0100);
    @(posedge clk);
    #1;
    chk("inc7_fu_en_off", 32'(fu_en), 32'd0);
    chk("inc7_valid", 32'(out_valid), 32'd1);
    chk("inc7_result", 32'(out_result), 32'h8);
    chk("inc7_zero", 32'(out_zero), 32'd0);
    chk("inc7_op", 32'(out_op), 32'd8);
    in_valid = 1'b0;
    drain();

    // Incrementor wrap F -> 0 with carry
    issue(OP_INC, 4'hF, 4'h0);
    @(posedge clk);
    #1;
    chk("incF_result", 32'(out_result), 32'h0);
    chk("incF_zero", 32'(out_zero), 32'd1);
    chk("incF_carry", 32'(out_carry), 32'd1);
    in_valid = 1'b0;
    drain();

    // Backpressure with a second request held at the input
    @(negedge clk);
    out_ready = 1'b0;
    issue(OP_ADD, 4'(($urandom)), 4'(($urandom)));
    @(negedge clk);
    in_valid = 1'b1;
    in_op = OP_SUB; in_a = 4'h3; in_b = 4'h5;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    r0 = out_result;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result", 32'(out_result), 32'(r0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    hs = cyc + 1;
    issue(OP_SUB, 4'h3, 4'h5);
    chk("bp_accept_cycle", 32'(last_acc), 32'(hs + 1));
    in_valid = 1'b0;
    drain();

    // Back-to-back, every opcode in order
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      issue(4'(i), 4'(($urandom)), 4'(($urandom)));
      if (i > 0) chk("b2b_spacing", 32'(last_acc - prev), 32'(S + 2));
      prev = last_acc;
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Random traffic with random consumer stalls and idle gaps
    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(4'(($urandom)), 4'(($urandom)), 4'(($urandom)));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset in the middle of DRIVE
    issue(OP_INC, 4'h3, 4'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fu_en", 32'(fu_en), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_zero", 32'(out_zero), 32'd1);
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid2", 32'(out_valid), 32'd0);

    // SETTLE=3 instance: incrementor 2 -> 3
    @(negedge clk);
    in_valid3 = 1'b1; in_op3 = OP_INC; in_a3 = 4'h2; in_b3 = 4'h0;
    out_ready3 = 1'b1;
    chk("s3_in_ready", 32'(in_ready3), 32'd1);
    @(posedge clk);
    #1;
    prev = cyc;
    hi = 0;
    n = 0;
    while (!out_valid3 && n < 20) begin
      @(negedge clk);
      in_valid3 = 1'b0;
      if (fu_en3 != 16'd0) begin
        hi++;
        chk("s3_fu_en", 32'(fu_en3), 32'h0100);
      end
      n++;
    end
    chk("s3_drive_len", 32'(hi), 32'(S3));
    chk("s3_latency", 32'(cyc - prev), 32'(S3));
    chk("s3_result", 32'(out_result3), 32'h3);
    chk("s3_zero", 32'(out_zero3), 32'd0);
    chk("s3_op", 32'(out_op3), 32'd8);

    repeat (3) @(negedge clk);
    chk("final_queue", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_op_controller.md
# alu_op_controller

Sequencing front-/back-end for the 4-bit, 16-function ALU. It accepts one operation request (opcode plus two operands) through a valid/ready handshake and registers the operands. It then drives exactly one function-unit enable line, including the incrementor's `E`, for a fixed settle window. Finally it captures the OR-combined result bus with flags into an output register, held until the consumer takes it.

## Interface
- `WIDTH`, 4: operand and result width.
- `NFUNC`, 16: number of function units, one enable bit each.
- `SETTLE`, 1: cycles `fu_en` is held before result capture; legal range 1..7.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  controller can accept a request.
- `in_op`  in  4  opcode, index into `fu_en`.
- `in_a`, `in_b`  in  WIDTH  operands.
- `fu_a`, `fu_b`  out  WIDTH  registered operands to all function units.
- `fu_en`  out  NFUNC  one-hot unit enable; the incrementor `E` is `fu_en[OP_INC]`.
- `fu_result`  in  WIDTH  OR of all unit outputs; disabled units output 0.
- `fu_carry`  in  1  carry/borrow of the enabled unit; units without carry drive 0.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  WIDTH  captured result.
- `out_op`  out  4  opcode that produced `out_result`.
- `out_zero`, `out_carry`  out  1  flags.

## Operation
- FSM states are IDLE, DRIVE, HOLD.
- **IDLE**
  - `in_ready`=1, `fu_en`=0.
  - On `in_valid`: register `in_op`/`in_a`/`in_b` into `fu_a`/`fu_b`/op register, load settle counter with SETTLE-1, go to DRIVE.
- **DRIVE**
  - `in_ready`=0; `fu_en` = one-hot(op) from register (glitch-free, no combinational path from `in_op`).
  - Counter decrements each cycle. At the edge where counter==0:
    - `out_result`←`fu_result`, `out_carry`←`fu_carry`, `out_zero`←(`fu_result`==0), `out_op`←op.
    - `fu_en` cleared, go to HOLD.
- **HOLD**
  - `out_valid`=1, `fu_en`=0, `in_ready`=0.
  - On `out_ready`: go to IDLE.
  - `out_*` data stays stable until the next capture; it is not cleared on leaving HOLD.
- `fu_a`/`fu_b` hold their last value outside DRIVE; only `fu_en` gates the units.
- `in_valid` while not in IDLE is ignored; the requester must hold it (standard valid/ready, no drop).
- All 16 opcodes are legal; no error path.
- **Reset (asynchronous, any state including mid-DRIVE)**
  - State IDLE, `fu_en`=0 immediately, `out_valid`=0, `in_ready`=1 after release.
  - `out_result`/`out_op`/`fu_a`/`fu_b`=0, `out_zero`=1, `out_carry`=0.
  - An in-flight operation is discarded.

## Timing
- Accept at edge k: `fu_en` is high in cycles k+1 .. k+SETTLE.
- Capture at edge k+SETTLE; `out_valid`=1 from cycle k+SETTLE+1.
- If `out_ready` is already high, HOLD lasts one cycle and `in_ready` rises in cycle k+SETTLE+2.
- Peak throughput is one op per SETTLE+2 cycles (3 at default).
- `fu_result` must be stable by the end of the last DRIVE cycle. Function units are purely combinational, so SETTLE=1 suffices at the target clock.
- Backpressure: HOLD persists indefinitely while `out_ready`=0; `out_*` is stable throughout.
- `in_ready` and `out_valid` are registered-state decodes with no combinational path from `in_valid`/`out_ready`.

## Structure
- Package `alu_pkg` holds:
  - opcode constants `OP_ADD`=0 … `OP_INC`=8 … (16 entries, one per function unit);
  - FSM state enum `alu_ctl_state_t` (IDLE, DRIVE, HOLD);
  - shared `WIDTH` default.
- Sub-module `onehot_dec` (4→16 decoder with enable); the FSM gates it with state==DRIVE.
- Flag generation stays inline.

## Test plan
- Reset mid-DRIVE (assert `rst_n`=0 during `fu_en` high) → `fu_en`=0 asynchronously, `out_valid`=0, `out_zero`=1, `in_ready`=1 after release.
- `OP_INC`, `in_a`=4'h7, SETTLE=1, real incrementor on `fu_en[8]` → `fu_en`=16'h0100 for exactly one cycle; `out_result`=4'h8, `out_zero`=0, `out_op`=8, `out_valid` two cycles after accept.
- `OP_INC`, `in_a`=4'hF → `out_result`=4'h0, `out_zero`=1, `out_carry` equals bench-driven `fu_carry`=1.
- Backpressure: `out_ready`=0 for 10 cycles after capture → `out_valid` held, `out_result` stable, `in_ready`=0, second request held at `in_valid` is accepted only on the cycle after `out_ready`=1.
- Back-to-back with `out_ready` tied high, 16 requests opcodes 0..15 → each `fu_en` one-hot matches opcode, never two bits set, accept spacing exactly 3 cycles.
- SETTLE=3 build, `OP_INC` `in_a`=4'h2 → `fu_en[8]` high 3 cycles, `out_result`=4'h3 valid at cycle k+4.
